branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised, pipelined branch/jump resolution stage for the execute path. Evaluates conditional branches, JAL and JALR from register operands, computes target and link addresses, and compares the result against the fetch-stage prediction to raise a mispredict/redirect. It owns a small branch history table (BHT) of 2-bit saturating counters. The table is read combinationally by fetch and trained by resolved conditional branches. Results leave through a one-entry output register with a valid/ready handshake.

Parameters:
XLEN, 32, datapath and address width (>= 8)
BHT_ENTRIES, 16, number of 2-bit counters; power of two, >= 2
IDX_LSB, 2, lowest PC bit used for the BHT index (index = pc[IDX_LSB +: log2(BHT_ENTRIES)])

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  squash the held result and the same-cycle input
in_valid  in  1  input operation valid
in_ready  out  1  unit can accept the input this cycle
pc  in  XLEN  PC of the instruction
src1_value  in  XLEN  rs1 operand
src2_value  in  XLEN  rs2 operand
imm  in  XLEN  sign-extended immediate
br_op  in  4  0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jal, 8 jalr; 9-15 treated as none
pred_taken  in  1  fetch prediction: taken
pred_pc  in  XLEN  fetch-predicted target (used only when pred_taken=1)
out_valid  out  1  result register holds a valid result
out_ready  in  1  consumer accepts the result
taken  out  1  resolved direction (1 for jal/jalr)
tgt_pc  out  XLEN  resolved target
link_pc  out  XLEN  pc+4
redirect_pc  out  XLEN  taken ? tgt_pc : link_pc
mispredict  out  1  fetch must redirect to redirect_pc
misaligned  out  1  taken and tgt_pc[1:0] != 0
lookup_pc  in  XLEN  fetch lookup address
lookup_taken  out  1  MSB of the indexed BHT counter (combinational)

Behaviour:
- in_ready = !out_valid || out_ready (combinational); accept = in_valid && in_ready && !flush.
- Latency 1: on accept, the result register loads at the next edge and out_valid=1. Otherwise, if out_valid && out_ready, out_valid becomes 0.
- Back-to-back: accept and drain in the same cycle gives a one-per-cycle throughput with no bubble.
- flush=1: out_valid becomes 0 at the next edge. Any input presented that cycle is dropped and does not train the BHT.
- Reset values: out_valid 0. taken, mispredict and misaligned 0. tgt_pc, link_pc and redirect_pc 0. All BHT counters 2'b01 (weakly not-taken). Reset mid-transfer discards the held result.
- Compare rules:
  - blt/bge use signed compare: $signed(src1) < $signed(src2).
  - bltu/bgeu use unsigned compare.
  - beq/bne compare for equality.
- Targets:
  - Branches and jal: tgt = pc + imm.
  - jalr: tgt = (src1 + imm) with bit 0 cleared.
  - Op none: taken=0 and tgt = link_pc.
  - All adds are modulo 2^XLEN; wrap-around is not flagged.
- link_pc = pc + 4, modulo 2^XLEN.
- mispredict = (taken != pred_taken) || (taken && tgt != pred_pc). For op none, mispredict = pred_taken.
- misaligned is reported alongside the result; the unit does not trap.
- BHT training:
  - Occurs on accept for br_op 1-6 only. The counter at pc's index increments if taken, decrements if not, saturating at 0 and 3.
  - jal, jalr and none never train.
- BHT lookup is read-before-write: if lookup and update hit the same index in one cycle, lookup_taken returns the pre-update value.
- Held result is stable while out_valid && !out_ready. Inputs are sampled only on accept.

Test Plan:
- beq, src1=src2=5, pc=0x100, imm=0x20, pred_taken=0 -> next cycle: taken=1, tgt_pc=0x120, redirect_pc=0x120, mispredict=1, link_pc=0x104.
- blt vs bltu, src1=0xFFFFFFFF, src2=1 -> blt taken=1; bltu taken=0. bge and bgeu give the complements.
- jalr, src1=0x2003, imm=0, pred_taken=1, pred_pc=0x2002 -> tgt_pc=0x2002, mispredict=0, misaligned=1. Same op with pred_pc=0x2000 -> mispredict=1.
- BHT: four taken bne at pc=0x40 -> lookup_pc=0x40 gives 0 after reset, 1 after the first update, and stays 1 through saturation. Three not-taken updates then return it to 0. A lookup in the same cycle as an update sees the old value.
- Handshake: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, the held result is stable, no BHT update. Then out_ready=1 continuously -> one result per cycle.
- flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, BHT unchanged. rst asserted mid-stream -> all outputs 0 immediately, counters read 2'b01.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: computes direction, target and link addresses, flags mispredicts,
// and trains a table of 2-bit saturating direction counters that fetch reads combinationally.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_LSB     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] src1_value,
    input  logic [XLEN-1:0] src2_value,
    input  logic [XLEN-1:0] imm,
    input  logic [3:0]      br_op,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pred_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] tgt_pc,
    output logic [XLEN-1:0] link_pc,
    output logic [XLEN-1:0] redirect_pc,
    output logic            mispredict,
    output logic            misaligned,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_BLT  = 4'd3;
    localparam logic [3:0] OP_BGE  = 4'd4;
    localparam logic [3:0] OP_BLTU = 4'd5;
    localparam logic [3:0] OP_BGEU = 4'd6;
    localparam logic [3:0] OP_JAL  = 4'd7;
    localparam logic [3:0] OP_JALR = 4'd8;

    logic            accept;
    logic            train;
    logic            is_branch;
    logic            taken_next;
    logic [XLEN-1:0] tgt_next;
    logic [XLEN-1:0] link_next;
    logic [XLEN-1:0] redirect_next;
    logic            mispredict_next;
    logic            misaligned_next;
    logic [XLEN-1:0] jalr_sum;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lookup_idx;

    logic            out_valid_reg;
    logic            taken_reg;
    logic [XLEN-1:0] tgt_reg;
    logic [XLEN-1:0] link_reg;
    logic [XLEN-1:0] redirect_reg;
    logic            mispredict_reg;
    logic            misaligned_reg;
    logic [1:0]      bht_reg [BHT_ENTRIES];

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign jalr_sum = src1_value + imm;
    assign link_next = pc + XLEN'(4);

    always_comb begin
        taken_next = 1'b0;
        is_branch  = 1'b1;
        tgt_next   = pc + imm;
        unique case (br_op)
            OP_BEQ:  taken_next = (src1_value == src2_value);
            OP_BNE:  taken_next = (src1_value != src2_value);
            OP_BLT:  taken_next = ($signed(src1_value) < $signed(src2_value));
            OP_BGE:  taken_next = !($signed(src1_value) < $signed(src2_value));
            OP_BLTU: taken_next = (src1_value < src2_value);
            OP_BGEU: taken_next = !(src1_value < src2_value);
            OP_JAL: begin
                taken_next = 1'b1;
                is_branch  = 1'b0;
            end
            OP_JALR: begin
                taken_next = 1'b1;
                is_branch  = 1'b0;
                tgt_next   = {jalr_sum[XLEN-1:1], 1'b0};
            end
            default: begin
                is_branch = 1'b0;
                tgt_next  = link_next;
            end
        endcase
    end

    // Op none resolves not-taken, so the general rule already yields mispredict = pred_taken.
    assign redirect_next   = taken_next ? tgt_next : link_next;
    assign mispredict_next = (taken_next != pred_taken) || (taken_next && (tgt_next != pred_pc));
    assign misaligned_next = taken_next && (tgt_next[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            taken_reg      <= 1'b0;
            tgt_reg        <= '0;
            link_reg       <= '0;
            redirect_reg   <= '0;
            mispredict_reg <= 1'b0;
            misaligned_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            taken_reg      <= taken_next;
            tgt_reg        <= tgt_next;
            link_reg       <= link_next;
            redirect_reg   <= redirect_next;
            mispredict_reg <= mispredict_next;
            misaligned_reg <= misaligned_next;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign taken       = taken_reg;
    assign tgt_pc      = tgt_reg;
    assign link_pc     = link_reg;
    assign redirect_pc = redirect_reg;
    assign mispredict  = mispredict_reg;
    assign misaligned  = misaligned_reg;

    // Direction counters; lookup reads the current value so same-cycle training is invisible until the edge.
    assign train      = accept && is_branch;
    assign upd_idx    = pc[IDX_LSB +: IDX_W];
    assign lookup_idx = lookup_pc[IDX_LSB +: IDX_W];

    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bht_reg[gi] <= 2'b01;
            end else if (train && (upd_idx == IDX_W'(gi))) begin
                if (taken_next && (bht_reg[gi] != 2'b11)) begin
                    bht_reg[gi] <= bht_reg[gi] + 2'b01;
                end else if (!taken_next && (bht_reg[gi] != 2'b00)) begin
                    bht_reg[gi] <= bht_reg[gi] - 2'b01;
                end
            end
        end
    end

    assign lookup_taken = bht_reg[lookup_idx][1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit: resolution, BHT training, handshake, flush, reset.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] src1_value;
    logic [31:0] src2_value;
    logic [31:0] imm;
    logic [3:0]  br_op;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] tgt_pc;
    logic [31:0] link_pc;
    logic [31:0] redirect_pc;
    logic        mispredict;
    logic        misaligned;
    logic [31:0] lookup_pc;
    logic        lookup_taken;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(16), .IDX_LSB(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .src1_value(src1_value), .src2_value(src2_value), .imm(imm),
        .br_op(br_op), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .tgt_pc(tgt_pc), .link_pc(link_pc), .redirect_pc(redirect_pc),
        .mispredict(mispredict), .misaligned(misaligned),
        .lookup_pc(lookup_pc), .lookup_taken(lookup_taken)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] p, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] im, input logic pt,
                          input logic [31:0] ppc);
        br_op = op; pc = p; src1_value = s1; src2_value = s2; imm = im;
        pred_taken = pt; pred_pc = ppc; in_valid = 1'b1;
    endtask

    // Send one op with out_ready=1 and leave the result in the output register.
    task automatic send(input logic [3:0] op, input logic [31:0] p, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] im, input logic pt,
                        input logic [31:0] ppc);
        set_op(op, p, s1, s2, im, pt, ppc);
        step();
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic t, input logic [31:0] tgt,
                           input logic [31:0] lnk, input logic mp, input logic ma);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".taken"}, 32'(taken), 32'(t));
        check({tag, ".tgt"}, tgt_pc, tgt);
        check({tag, ".link"}, link_pc, lnk);
        check({tag, ".redirect"}, redirect_pc, t ? tgt : lnk);
        check({tag, ".mispredict"}, 32'(mispredict), 32'(mp));
        check({tag, ".misaligned"}, 32'(misaligned), 32'(ma));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; src1_value = '0; src2_value = '0; imm = '0; br_op = '0;
        pred_taken = 1'b0; pred_pc = '0; lookup_pc = 32'h40;
        step(); step();
        rst = 1'b0;

        // Reset state
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.taken", 32'(taken), 32'd0);
        check("rst.tgt", tgt_pc, 32'h0);
        check("rst.link", link_pc, 32'h0);
        check("rst.redirect", redirect_pc, 32'h0);
        check("rst.mispredict", 32'(mispredict), 32'd0);
        check("rst.misaligned", 32'(misaligned), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.lookup", 32'(lookup_taken), 32'd0);

        // Resolution vectors
        send(4'd1, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
        chk_res("beq", 1'b1, 32'h120, 32'h104, 1'b1, 1'b0);
        send(4'd3, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 32'h0);
        chk_res("blt", 1'b1, 32'h208, 32'h204, 1'b1, 1'b0);
        send(4'd5, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b0, 32'h0);
        chk_res("bltu", 1'b0, 32'h208, 32'h204, 1'b0, 1'b0);
        send(4'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1, 32'h208);
        chk_res("bge", 1'b0, 32'h208, 32'h204, 1'b1, 1'b0);
        send(4'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1, 32'h208);
        chk_res("bgeu", 1'b1, 32'h208, 32'h204, 1'b0, 1'b0);
        send(4'd8, 32'h1000, 32'h2003, 32'd0, 32'h0, 1'b1, 32'h2002);
        chk_res("jalr.hit", 1'b1, 32'h2002, 32'h1004, 1'b0, 1'b1);
        send(4'd8, 32'h1000, 32'h2003, 32'd0, 32'h0, 1'b1, 32'h2000);
        chk_res("jalr.miss", 1'b1, 32'h2002, 32'h1004, 1'b1, 1'b1);
        send(4'd7, 32'h300, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b1, 32'h2F8);
        chk_res("jal.neg", 1'b1, 32'h2F8, 32'h304, 1'b0, 1'b0);
        send(4'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h10, 1'b1, 32'h0);
        chk_res("none.wrap", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        send(4'd12, 32'h400, 32'd1, 32'd2, 32'h10, 1'b0, 32'h0);
        chk_res("op12", 1'b0, 32'h404, 32'h404, 1'b0, 1'b0);

        // BHT training at pc 0x40: expected MSB sequence 1,1,1,1 then 1,0,0
        do_reset();
        check("bht.init", 32'(lookup_taken), 32'd0);
        for (int i = 0; i < 4; i++) begin
            send(4'd2, 32'h40, 32'd1, 32'd2, 32'h40, 1'b0, 32'h0);
            check($sformatf("bht.up%0d", i), 32'(lookup_taken), 32'd1);
        end
        send(4'd2, 32'h40, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
        check("bht.dn0", 32'(lookup_taken), 32'd1);
        send(4'd2, 32'h40, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
        check("bht.dn1", 32'(lookup_taken), 32'd0);
        send(4'd2, 32'h40, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
        check("bht.dn2", 32'(lookup_taken), 32'd0);
        // Counter 00 -> 01 -> 10 with taken, then a same-cycle not-taken update reads the old MSB
        send(4'd1, 32'h40, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
        check("bht.r01", 32'(lookup_taken), 32'd0);
        send(4'd1, 32'h40, 32'd3, 32'd3, 32'h40, 1'b0, 32'h0);
        check("bht.r10", 32'(lookup_taken), 32'd1);
        set_op(4'd1, 32'h40, 32'd3, 32'd4, 32'h40, 1'b0, 32'h0);
        #1;
        check("bht.rbw.same", 32'(lookup_taken), 32'd1);
        step();
        in_valid = 1'b0;
        check("bht.rbw.after", 32'(lookup_taken), 32'd0);
        send(4'd7, 32'h40, 32'd0, 32'd0, 32'h40, 1'b1, 32'h80);
        send(4'd8, 32'h40, 32'd0, 32'd0, 32'h40, 1'b1, 32'h40);
        send(4'd0, 32'h40, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0);
        check("bht.jumps.notrain", 32'(lookup_taken), 32'd0);

        // Handshake: stall then stream
        do_reset();
        out_ready = 1'b0;
        send(4'd7, 32'h500, 32'd0, 32'd0, 32'h10, 1'b0, 32'h0);
        chk_res("hs.A", 1'b1, 32'h510, 32'h504, 1'b1, 1'b0);
        set_op(4'd2, 32'h40, 32'd1, 32'd2, 32'h40, 1'b1, 32'h80);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hs.stall%0d.in_ready", i), 32'(in_ready), 32'd0);
            step();
            check($sformatf("hs.stall%0d.tgt", i), tgt_pc, 32'h510);
            check($sformatf("hs.stall%0d.valid", i), 32'(out_valid), 32'd1);
            check($sformatf("hs.stall%0d.lookup", i), 32'(lookup_taken), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("hs.release.in_ready", 32'(in_ready), 32'd1);
        step();
        chk_res("hs.B", 1'b1, 32'h80, 32'h44, 1'b0, 1'b0);
        check("hs.B.lookup", 32'(lookup_taken), 32'd1);
        set_op(4'd6, 32'h600, 32'd3, 32'd7, 32'h4, 1'b0, 32'h0);
        step();
        chk_res("hs.C", 1'b0, 32'h604, 32'h604, 1'b0, 1'b0);
        set_op(4'd3, 32'h700, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h100, 1'b1, 32'h800);
        step();
        chk_res("hs.D", 1'b1, 32'h800, 32'h704, 1'b0, 1'b0);
        in_valid = 1'b0;
        step();
        check("hs.drain.valid", 32'(out_valid), 32'd0);

        // Flush with a held result and a same-cycle not-taken branch
        out_ready = 1'b0;
        send(4'd7, 32'h500, 32'd0, 32'd0, 32'h10, 1'b0, 32'h0);
        check("fl.pre.valid", 32'(out_valid), 32'd1);
        set_op(4'd1, 32'h40, 32'd1, 32'd2, 32'h40, 1'b0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl.valid", 32'(out_valid), 32'd0);
        check("fl.lookup", 32'(lookup_taken), 32'd1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(4'd2, 32'h40, 32'd1, 32'd2, 32'h44, 1'b0, 32'h0);
        check("ar.pre.valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("ar.valid", 32'(out_valid), 32'd0);
        check("ar.taken", 32'(taken), 32'd0);
        check("ar.tgt", tgt_pc, 32'h0);
        check("ar.link", link_pc, 32'h0);
        check("ar.redirect", redirect_pc, 32'h0);
        check("ar.mispredict", 32'(mispredict), 32'd0);
        check("ar.lookup", 32'(lookup_taken), 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        send(4'd2, 32'h40, 32'd1, 32'd2, 32'h44, 1'b0, 32'h0);
        check("ar.cnt01.lookup", 32'(lookup_taken), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
